intr_ctrl: RTL and testbench

- Interrupt controller directly upstream of the CSR block.
- Synchronizes N external interrupt lines and latches their rising edges as pending.
- Arbitrates among pending sources, handshakes with the control FSM at an instruction boundary, and emits the one-cycle int_taken pulse that the CSR block consumes to save mepc and clear mie.
- Tracks handler occupancy until mret, and exports the serviced source ID for software.

---
 rtl/intr_ctrl_pkg.sv | 16 +
 rtl/irq_sync_edge.sv | 28 ++
 rtl/intr_ctrl.sv | 89 ++++++++
 tb/tb_intr_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller
// and the CSR decoder.
package intr_ctrl_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HANDLER = 1'b1
  } state_e;

  localparam logic [11:0] CSR_MIE   = 12'h304;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC  = 12'h341;

  localparam int DEF_N_SRC = 4;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one interrupt line plus a
// third flop that turns a synchronized rising edge into a pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/intr_ctrl.sv
// Edge-latched, fixed-priority interrupt controller that
// hands one trap at a time to the control FSM.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             csr_mie,
  input  logic             instr_boundary,
  input  logic             mret,
  output logic             int_req,
  output logic             int_taken,
  output logic [ID_W-1:0]  int_id,
  output logic             in_handler,
  output logic [N_SRC-1:0] pending
);

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] r_pend;
  logic [ID_W-1:0]  w_sel;
  logic [ID_W-1:0]  r_id;
  state_e           r_state;
  state_e           w_state_nxt;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_irq  (irq_in[g]),
      .o_rise (w_rise[g])
    );
  end

  // Scan high to low so the lowest pending index wins.
  always_comb begin
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (r_pend[i]) w_sel = ID_W'(i);
    end
  end

  assign w_clr = int_taken ? (N_SRC'(1) << w_sel) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (int_taken) w_state_nxt = ST_HANDLER;
      ST_HANDLER: if (mret)      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    int_req    = 1'b0;
    in_handler = 1'b0;
    unique case (r_state)
      ST_IDLE:    int_req    = csr_mie & (|r_pend);
      ST_HANDLER: in_handler = 1'b1;
    endcase
    int_taken = int_req & instr_boundary;
  end

  // A fresh edge landing on its own clear keeps the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_id   <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (int_taken) r_id <= w_sel;
    end
  end

  assign pending = r_pend;
  assign int_id  = r_id;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scenario tasks plus a randomized run, all checked
// against a cycle-level behavioural model.
module tb_intr_ctrl;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         csr_mie = 1'b0;
  logic         instr_boundary = 1'b0;
  logic         mret = 1'b0;
  logic         int_req;
  logic         int_taken;
  logic [W-1:0] int_id;
  logic         in_handler;
  logic [N-1:0] pending;

  int n_pass = 0;
  int n_tot  = 0;

  intr_ctrl #(.N_SRC(N), .ID_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_in         (irq_in),
    .csr_mie        (csr_mie),
    .instr_boundary (instr_boundary),
    .mret           (mret),
    .int_req        (int_req),
    .int_taken      (int_taken),
    .int_id         (int_id),
    .in_handler     (in_handler),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  // Model: an edge seen in sample k sets pending at edge k+2.
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_sched [4] = '{default: '0};
  logic         m_inh = 1'b0;
  logic [W-1:0] m_id = '0;
  int unsigned  m_cyc = 0;

  function automatic int low_idx(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend <= '0;
      m_prev <= '0;
      for (int i = 0; i < 4; i++) m_sched[i] <= '0;
      m_inh <= 1'b0;
      m_id  <= '0;
      m_cyc <= 0;
    end else begin
      automatic logic tk = !m_inh && csr_mie && (m_pend != '0)
                           && instr_boundary;
      automatic int s = low_idx(m_pend);
      automatic logic [N-1:0] clr = tk ? (N'(1) << s) : '0;
      m_pend <= (m_pend & ~clr) | m_sched[m_cyc % 4];
      m_sched[m_cyc % 4] <= '0;
      m_sched[(m_cyc + 2) % 4] <= m_sched[(m_cyc + 2) % 4]
                                  | (irq_in & ~m_prev);
      m_prev <= irq_in;
      m_cyc  <= m_cyc + 1;
      if (tk) begin
        m_id  <= W'(s);
        m_inh <= 1'b1;
      end else if (m_inh && mret) begin
        m_inh <= 1'b0;
      end
    end
  end

  wire e_req   = !m_inh && csr_mie && (m_pend != '0);
  wire e_taken = e_req && instr_boundary;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_take(output bit found, output int lat);
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int_taken === 1'b1) begin
        found = 1'b1;
        lat   = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit f;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    n_tot++;
    if ({int_req, int_taken, in_handler, int_id, pending} !== '0)
      $display("FAIL reset_state got %0h want 0",
               {int_req, int_taken, in_handler, int_id, pending});
    else n_pass++;
    rst = 1'b1;
    step();
    csr_mie = 1'b1;
    instr_boundary = 1'b1;
    irq_in[2] = 1'b1;
    wait_take(f, lat);
    n_tot++;
    if (!f || lat != 3)
      $display("FAIL first_take found=%0d lat=%0d want 1/3", f, lat);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if ({int_taken, in_handler, int_id, pending} !== {1'b0, 1'b1, 4'd2, 4'd0})
      $display("FAIL handler_entry got %0h want %0h",
               {int_taken, in_handler, int_id, pending},
               {1'b0, 1'b1, 4'd2, 4'd0});
    else n_pass++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    irq_in = '0;
    #1;
    n_tot++;
    if ({int_req, int_taken, in_handler, int_id, pending} !== '0)
      $display("FAIL async_reset got %0h want 0",
               {int_req, int_taken, in_handler, int_id, pending});
    else n_pass++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tot++;
      if (int_req !== 1'b0)
        $display("FAIL post_reset_req cyc %0d got %b want 0", i, int_req);
      else n_pass++;
    end
  endtask

  task automatic test_priority();
    bit f;
    int lat;
    step();
    irq_in = 4'b1010;
    wait_take(f, lat);
    n_tot++;
    if (!f || pending !== 4'b1010)
      $display("FAIL prio_take found=%0d pend=%b want 1/1010", f, pending);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if ({int_id, pending, in_handler} !== {4'd1, 4'b1000, 1'b1})
      $display("FAIL prio_first got %0h want %0h",
               {int_id, pending, in_handler}, {4'd1, 4'b1000, 1'b1});
    else n_pass++;
    step();
    mret = 1'b1;
    @(negedge clk);
    n_tot++;
    if (int_taken !== 1'b0)
      $display("FAIL mret_cycle_take got %b want 0", int_taken);
    else n_pass++;
    step();
    mret = 1'b0;
    @(negedge clk);
    n_tot++;
    if (int_taken !== 1'b1)
      $display("FAIL prio_second_take got %b want 1", int_taken);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if ({int_id, pending} !== {4'd3, 4'b0000})
      $display("FAIL prio_second got %0h want %0h",
               {int_id, pending}, {4'd3, 4'b0000});
    else n_pass++;
    step();
    mret = 1'b1;
    irq_in = '0;
    step();
    mret = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_masking();
    csr_mie = 1'b0;
    instr_boundary = 1'b1;
    irq_in[0] = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tot++;
      if ({int_req, int_taken} !== 2'b00)
        $display("FAIL masked_req cyc %0d got %b want 00", i,
                 {int_req, int_taken});
      else n_pass++;
    end
    n_tot++;
    if (pending !== 4'b0001)
      $display("FAIL masked_pend got %b want 0001", pending);
    else n_pass++;
    step();
    csr_mie = 1'b1;
    #1;
    n_tot++;
    if ({int_req, int_taken} !== 2'b11)
      $display("FAIL unmask_same_cycle got %b want 11", {int_req, int_taken});
    else n_pass++;
    step();
    n_tot++;
    if ({in_handler, int_id} !== {1'b1, 4'd0})
      $display("FAIL unmask_take got %0h want %0h",
               {in_handler, int_id}, {1'b1, 4'd0});
    else n_pass++;
    mret = 1'b1;
    step();
    mret = 1'b0;
  endtask

  task automatic test_gating();
    int cnt;
    instr_boundary = 1'b0;
    irq_in[3] = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tot++;
      if ({int_req, int_taken} !== 2'b10)
        $display("FAIL gated cyc %0d got %b want 10", i, {int_req, int_taken});
      else n_pass++;
    end
    step();
    instr_boundary = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (int_taken === 1'b1) cnt++;
    end
    n_tot++;
    if (cnt != 1)
      $display("FAIL gate_release_takes got %0d want 1", cnt);
    else n_pass++;
    step();
    instr_boundary = 1'b0;
    irq_in = '0;
    mret = 1'b1;
    step();
    mret = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reentry();
    bit f;
    int lat;
    instr_boundary = 1'b1;
    irq_in[2] = 1'b1;
    wait_take(f, lat);
    n_tot++;
    if (!f) $display("FAIL reentry_first_take got 0 want 1");
    else n_pass++;
    step();
    instr_boundary = 1'b0;
    irq_in[0] = 1'b1;
    repeat (4) step();
    @(negedge clk);
    n_tot++;
    if ({pending[0], int_req, in_handler} !== 3'b101)
      $display("FAIL nested_blocked got %b want 101",
               {pending[0], int_req, in_handler});
    else n_pass++;
    step();
    mret = 1'b1;
    instr_boundary = 1'b1;
    @(negedge clk);
    n_tot++;
    if (int_taken !== 1'b0)
      $display("FAIL mret_boundary_take got %b want 0", int_taken);
    else n_pass++;
    step();
    mret = 1'b0;
    @(negedge clk);
    n_tot++;
    if (int_taken !== 1'b1)
      $display("FAIL after_mret_take got %b want 1", int_taken);
    else n_pass++;
    step();
    instr_boundary = 1'b0;
    n_tot++;
    if ({int_id, in_handler} !== {4'd0, 1'b1})
      $display("FAIL after_mret_id got %0h want %0h",
               {int_id, in_handler}, {4'd0, 1'b1});
    else n_pass++;
    irq_in = '0;
    mret = 1'b1;
    step();
    mret = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_edge();
    int cnt;
    instr_boundary = 1'b1;
    csr_mie = 1'b1;
    mret = 1'b1;
    irq_in[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (int_taken === 1'b1) cnt++;
      step();
    end
    n_tot++;
    if (cnt != 1 || pending !== 4'b0000)
      $display("FAIL level_held takes=%0d pend=%b want 1/0000", cnt, pending);
    else n_pass++;
    mret = 1'b0;
    instr_boundary = 1'b0;
    irq_in[1] = 1'b0;
    repeat (3) step();
    irq_in[1] = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_tot++;
    if ({pending[1], int_req} !== 2'b11)
      $display("FAIL coll_setup got %b want 11", {pending[1], int_req});
    else n_pass++;
    step();
    irq_in[1] = 1'b0;
    repeat (3) step();
    irq_in[1] = 1'b1;
    step();
    step();
    instr_boundary = 1'b1;
    @(negedge clk);
    n_tot++;
    if (int_taken !== 1'b1)
      $display("FAIL coll_take got %b want 1", int_taken);
    else n_pass++;
    step();
    instr_boundary = 1'b0;
    @(negedge clk);
    n_tot++;
    if ({pending[1], in_handler, int_id} !== {1'b1, 1'b1, 4'd1})
      $display("FAIL set_wins got %0h want %0h",
               {pending[1], in_handler, int_id}, {1'b1, 1'b1, 4'd1});
    else n_pass++;
    step();
    mret = 1'b1;
    step();
    mret = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step();
      if ($urandom_range(0, 5) == 0)
        irq_in = irq_in ^ (N'(1) << $urandom_range(0, N - 1));
      csr_mie = ($urandom_range(0, 3) != 0);
      instr_boundary = 1'($urandom_range(0, 1));
      mret = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      n_tot++;
      if ({int_req, int_taken, in_handler, int_id, pending} !==
          {e_req, e_taken, m_inh, m_id, m_pend})
        $display("FAIL random cyc %0d got %0h want %0h", i,
                 {int_req, int_taken, in_handler, int_id, pending},
                 {e_req, e_taken, m_inh, m_id, m_pend});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_masking();
    test_gating();
    test_reentry();
    test_edge();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
